// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch
// Brief    : Instruction fetch unit with a DEPTH-entry prefetch queue between
//            an active-low req/grant/strobe/ready bus and the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_prefetch #(
    parameter int                ADDR_W = 30,
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              bus_reqn,
    input  logic              bus_grntn,
    output logic              bus_asn,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rdyn,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              busy
);

    localparam int               c_ptr_w = $clog2(DEPTH);
    localparam int               c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ADDR   = 2'd2,
        S_ACCESS = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic                r_discard;
    logic [ADDR_W-1:0]   r_q_pc   [DEPTH];
    logic [DATA_W-1:0]   r_q_insn [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  w_count_next;
    logic [ADDR_W-1:0]   r_if_pc;
    logic [DATA_W-1:0]   r_if_insn;
    logic                r_if_en;

    logic                w_redirect;
    logic [ADDR_W-1:0]   w_target;
    logic                w_rdy;
    logic                w_push;
    logic                w_pop;
    logic                w_reqn;
    logic                w_asn;
    logic [ADDR_W-1:0]   w_addr;

    always_comb begin
        w_redirect = flush | br_taken;
        w_target   = flush ? new_pc : br_addr;
        w_rdy      = (r_state == S_ACCESS) && !bus_rdyn;
        // A response coinciding with a redirect belongs to the old stream.
        w_push     = w_rdy && !r_discard && !w_redirect;
        w_pop      = !w_redirect && !stall && (r_count != '0);
    end

    always_comb begin
        w_count_next = r_count;
        if (w_redirect) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + c_cnt_w'(1);
                2'b01:   w_count_next = r_count - c_cnt_w'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_reqn       = 1'b1;
        w_asn        = 1'b1;
        w_addr       = '0;
        case (r_state)
            S_IDLE: begin
                if (r_count < c_depth) begin
                    w_reqn       = 1'b0;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_reqn = 1'b0;
                if (!bus_grntn) begin
                    w_state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                w_reqn       = 1'b0;
                w_asn        = 1'b0;
                w_addr       = r_fetch_pc;
                w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                w_reqn = 1'b0;
                if (w_rdy) begin
                    // Back-to-back only if the next access still has a queue slot.
                    if ((w_count_next < c_depth) && !w_redirect && !bus_grntn) begin
                        w_state_next = S_ADDR;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
        endcase
    end

    assign bus_reqn = cpu_rst | w_reqn;
    assign bus_asn  = cpu_rst | w_asn;
    assign bus_addr = cpu_rst ? '0 : w_addr;
    assign busy     = !cpu_rst && (r_state != S_IDLE);
    assign if_pc    = r_if_pc;
    assign if_insn  = r_if_insn;
    assign if_en    = r_if_en;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RST_PC;
            r_discard  <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_if_en    <= 1'b0;
            r_if_pc    <= '0;
            r_if_insn  <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;

            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_rdy && !r_discard) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
            end

            // The access issued before a redirect is still on the bus; drop its data.
            if (w_rdy) begin
                r_discard <= 1'b0;
            end else if (w_redirect && ((r_state == S_ADDR) || (r_state == S_ACCESS))) begin
                r_discard <= 1'b1;
            end

            if (w_redirect) begin
                r_if_en   <= 1'b0;
                r_if_insn <= '0;
            end else if (!stall) begin
                if (w_pop) begin
                    r_if_en   <= 1'b1;
                    r_if_pc   <= r_q_pc[r_rd_ptr];
                    r_if_insn <= r_q_insn[r_rd_ptr];
                end else begin
                    r_if_en   <= 1'b0;
                    r_if_insn <= '0;
                end
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_fetch_pc;
            r_q_insn[r_wr_ptr] <= bus_rdata;
        end
    end

endmodule
`default_nettype wire
